// File: rtl/program_sequencer.sv
// program_sequencer: program counter with a return-address stack.
// Each rising edge performs exactly one action, chosen by priority:
// stall > ret > call > jump > increment. A call on a full stack or a ret on
// an empty stack falls back to a plain increment and sets a sticky flag.
// All outputs come straight from registers.
module program_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [DEPTH_W-1:0] DEPTH_EMPTY = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL  = DEPTH_W'(STACK_DEPTH);

  // Action selected for the coming edge.
  localparam logic [2:0] ACT_HOLD  = 3'd0;  // stall: nothing moves
  localparam logic [2:0] ACT_POP   = 3'd1;  // ret with entries available
  localparam logic [2:0] ACT_UNDER = 3'd2;  // ret on empty stack
  localparam logic [2:0] ACT_PUSH  = 3'd3;  // call with room on the stack
  localparam logic [2:0] ACT_OVER  = 3'd4;  // call on full stack
  localparam logic [2:0] ACT_JUMP  = 3'd5;  // plain jump
  localparam logic [2:0] ACT_INC   = 3'd6;  // sequential fetch

  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic [DEPTH_W-1:0] depth_q,     depth_d;
  logic               overflow_q,  overflow_d;
  logic               underflow_q, underflow_d;

  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic [2:0]         act;
  logic [ADDR_W-1:0]  pc_inc;
  logic               stack_empty;
  logic               stack_full;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;
  logic               push_en;

  // pc+1 wraps naturally at 2^ADDR_W; this is also the return address.
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_empty = (depth_q == DEPTH_EMPTY);
  assign stack_full  = (depth_q == DEPTH_FULL);

  // The next free slot is stack[depth]; the top is stack[depth-1]. Only the
  // low index bits are kept: a push never happens when depth equals
  // STACK_DEPTH, and a pop never happens when depth is zero, so the
  // truncated or wrapped indices are only ever used when they are in range.
  assign push_idx = depth_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);

  // Priority decode of the control inputs into a single action.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    act = ACT_INC;
    if (stall) begin
      act = ACT_HOLD;
    end else if (ret) begin
      act = stack_empty ? ACT_UNDER : ACT_POP;
    end else if (call) begin
      act = stack_full ? ACT_OVER : ACT_PUSH;
    end else if (jump) begin
      act = ACT_JUMP;
    end
  end

  // Next-state values for pc, depth and the sticky flags.
  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
    case (act)
      ACT_HOLD: ;
      ACT_POP: begin
        pc_d    = stack_q[pop_idx];
        depth_d = depth_q - DEPTH_W'(1);
      end
      ACT_UNDER: begin
        pc_d        = pc_inc;
        underflow_d = 1'b1;
      end
      ACT_PUSH: begin
        pc_d    = target;
        depth_d = depth_q + DEPTH_W'(1);
        push_en = 1'b1;
      end
      ACT_OVER: begin
        pc_d       = pc_inc;
        overflow_d = 1'b1;
      end
      ACT_JUMP: pc_d = target;
      default:  pc_d = pc_inc;
    endcase
  end

  // Control state: pc, stack depth and sticky flags, cleared asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge value of its inputs, regardless of block ordering.
      pc_q        <= RESET_ADDR;
      depth_q     <= DEPTH_EMPTY;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage, written on a successful call.
  // NOTE: the stack array has no reset; depth=0 after clr makes every entry
  // unreachable, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
